timer_dev: RTL
==============

// Module: timer_dev
// PURPOSE
// - Memory-mapped countdown timer on the CPU data bus, downstream of the MEM stage: the CPU's
//   data address/write-data/write-enable reach it in parallel with DM, and its read data
//   merges into the MEM-stage read mux.
// - Three word registers, one FSM, a level/pulse interrupt output for the future CP0 block.
// - Address decode (base select) lives in the system bridge; this block sees the word offset only.
// PARAMETERS
// - PRESET_RST  32'h0  reset value of PRESET
// PORTS
// - clk    in   1   system clock; all state changes on rising edge
// - rst    in   1   asynchronous reset, active-low (0 = reset)
// - addr   in   2   word offset: 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved
// - we     in   1   write strobe, already qualified by the bridge's base decode
// - wd     in   32  write data
// - rd     out  32  read data, combinational from addr
// - irq    out  1   interrupt request
// BEHAVIOUR
// - Registers:
//   - CTRL[0] EN, CTRL[2:1] MODE (00 one-shot, 01 auto-reload, 1x treated as 00), CTRL[3] IM
//     (irq mask, 1 = enabled).
//   - Other CTRL bits read 0.
//   - PRESET R/W.
//   - COUNT read-only; writes ignored.
//   - addr=3 reads 0, writes ignored.
// - Reset (rst=0, async): CTRL=0, PRESET=PRESET_RST, COUNT=0, state=IDLE, irq_flag=0, irq=0.
// - FSM states IDLE, LOAD, CNT, INT:
//   - IDLE: EN=1 -> LOAD, else stay; COUNT holds.
//   - LOAD: COUNT<=PRESET -> CNT.
//   - CNT: EN=0 -> IDLE (COUNT holds); COUNT==0 -> INT; else COUNT<=COUNT-1 (no underflow).
//   - INT, MODE 00: EN<=0, irq_flag<=1 -> IDLE.
//   - INT, MODE 01: one-cycle pulse, irq_flag untouched -> LOAD.
// - irq:
//   - MODE 00: irq = irq_flag & IM, held until CTRL or PRESET is written (any write clears irq_flag).
//   - MODE 01: irq = (state==INT) & IM, a 1-cycle pulse.
// - Latency, EN written in cycle N:
//   - LOAD in N+1, first CNT in N+2.
//   - For PRESET=P, INT is entered P+1 cycles after the first CNT cycle.
// - CTRL write in any state:
//   - Overrides that cycle's FSM step: next state = new EN ? LOAD : IDLE.
//   - COUNT does not decrement in that cycle; a pending INT is dropped.
// - PRESET write: affects only the next LOAD; current COUNT is unaffected.
// - Simultaneous CTRL write and INT entry: the write wins; no irq_flag set, no pulse.
// - rd reflects register state before the current edge (read-during-write returns the old value).
// - Reset mid-count: immediate return to reset values; no irq glitch (irq is registered-derived).
// CONFIGURATION
// - TIMER_PRESCALE_EN defined:
//   - CTRL[7:4] = PS, R/W.
//   - In CNT, decrement/zero-check occurs only when an internal free-running prescale counter
//     hits 2^PS-1; that counter clears on LOAD.
//   - PS=0 is identical to the undefined case.
// - TIMER_PRESCALE_EN undefined: CTRL[7:4] read 0, writes ignored, no prescale counter
//   synthesized; decrement every CNT cycle.
// TESTING
// - Reset, then read addr 0/1/2 -> rd = 0, PRESET_RST, 0; irq=0.
// - PRESET=5, CTRL=0x9 (EN, one-shot, IM):
//   - COUNT steps 5..0; INT 8 cycles after the CTRL write edge; irq rises and holds.
//   - CTRL reads 0x8.
//   - CTRL write 0x8 -> irq drops next cycle.
// - PRESET=2, CTRL=0xB (auto-reload):
//   - irq pulses 1 cycle every 5 cycles (LOAD+3 CNT+INT) for 3 periods.
//   - CTRL IM=0 -> no pulses while COUNT still cycles.
// - Mid-count CTRL=0 at COUNT=3 -> IDLE, COUNT holds 3, irq stays 0.
//   - Write to COUNT (addr 2, 0x55) ignored.
// - CTRL write in same cycle CNT sees COUNT==0 -> no irq; rst=0 asserted mid-CNT -> all outputs
//   reset asynchronously.
// - With TIMER_PRESCALE_EN: PS=2, PRESET=1 -> COUNT changes every 4 cycles; INT 8 cycles after
//   first CNT.

Source files
------------

// File: rtl/timer_dev.sv
// timer_dev: memory-mapped countdown timer with a one-shot / auto-reload FSM and an interrupt
// output. Registers: 0=CTRL, 1=PRESET, 2=COUNT (read-only), 3=reserved.
// Optional feature: define TIMER_PRESCALE_EN to add a CTRL[7:4] prescaler (2^PS cycles per tick).
module timer_dev #(
  parameter logic [31:0] PRESET_RST = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        irq
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StCnt  = 2'd2,
    StInt  = 2'd3
  } state_e;

`ifdef TIMER_PRESCALE_EN
  localparam int unsigned CtrlW = 8;
`else
  localparam int unsigned CtrlW = 4;
`endif

  state_e           state_q, state_d;
  logic [CtrlW-1:0] ctrl_q, ctrl_d;
  logic [31:0]      preset_q, preset_d;
  logic [31:0]      count_q, count_d;
  logic             irq_flag_q, irq_flag_d;

  logic ctrl_we, preset_we;
  logic en, im, auto_reload;
  logic tick;

  assign ctrl_we     = we && (addr == 2'd0);
  assign preset_we   = we && (addr == 2'd1);
  assign en          = ctrl_q[0];
  assign im          = ctrl_q[3];
  // MODE 1x behaves as one-shot, so only 01 selects auto-reload.
  assign auto_reload = (ctrl_q[2:1] == 2'b01);

`ifdef TIMER_PRESCALE_EN
  logic [14:0] ps_cnt_q, ps_cnt_d;
  logic [14:0] ps_term;

  // Terminal prescale value is 2^PS-1; PS=0 ticks every cycle.
  assign ps_term = 15'((32'd1 << ctrl_q[7:4]) - 32'd1);
  assign tick    = (ps_cnt_q == ps_term);

  // Free-running prescale counter, realigned to zero while in LOAD.
  always_comb begin
    ps_cnt_d = ps_cnt_q + 15'd1;
    if (state_q == StLoad || tick) begin
      ps_cnt_d = '0;
    end
  end

  // Prescale counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ps_cnt_q <= '0;
    end else begin
      ps_cnt_q <= ps_cnt_d;
    end
  end
`else
  assign tick = 1'b1;
`endif

  // Next-state logic: normal FSM step, then a CTRL write overrides the whole step.
  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    // Any CTRL/PRESET write acknowledges a held one-shot interrupt.
    irq_flag_d = irq_flag_q & ~(ctrl_we | preset_we);

    if (preset_we) begin
      preset_d = wd;
    end

    unique case (state_q)
      StIdle: begin
        if (en) begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        count_d = preset_q;
        state_d = StCnt;
      end
      StCnt: begin
        if (!en) begin
          state_d = StIdle;
        end else if (tick) begin
          if (count_q == 32'd0) begin
            state_d = StInt;
          end else begin
            count_d = count_q - 32'd1;
          end
        end
      end
      StInt: begin
        if (auto_reload) begin
          state_d = StLoad;
        end else begin
          ctrl_d[0]  = 1'b0;
          irq_flag_d = 1'b1;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // A CTRL write wins over everything the FSM wanted this cycle.
    if (ctrl_we) begin
      ctrl_d     = wd[CtrlW-1:0];
      state_d    = wd[0] ? StLoad : StIdle;
      count_d    = count_q;
      irq_flag_d = 1'b0;
    end
  end

  // State and register bank.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      ctrl_q     <= '0;
      preset_q   <= PRESET_RST;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  // Read mux and interrupt, both purely from registered state.
  always_comb begin
    rd = 32'd0;
    unique case (addr)
      2'd0:    rd = {{(32 - CtrlW){1'b0}}, ctrl_q};
      2'd1:    rd = preset_q;
      2'd2:    rd = count_q;
      default: rd = 32'd0;
    endcase
    irq = im & (auto_reload ? (state_q == StInt) : irq_flag_q);
  end

endmodule
